pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Consumes the iCE40 PLL LOCK output and generates the system reset for logic clocked by the PLL output.
- Runs on the always-running reference clock, because the PLL output is invalid before lock.
- Synchronises and qualifies lock, then releases reset only after lock has been stable and a hold period has elapsed.
- Re-asserts reset on any loss of lock and counts lock-loss events for debug.

Parameters:
- STABLE_CYCLES, 1024: consecutive synchronised-lock-high cycles required before leaving STABILIZE (min 1).
- HOLD_CYCLES, 16: extra cycles that sys_reset stays high after lock is qualified (min 1).
- LOSS_CNT_W, 8: width of the lock-loss counter.
- TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK before a timeout (used only with the optional feature).

Ports:
- clk, input, 1: reference clock (PLL REFERENCECLK domain).
- reset, input, 1: synchronous active-high reset.
- pll_lock, input, 1: raw PLL LOCK, asynchronous to clk.
- sys_reset, output, 1: active-high reset for downstream logic.
- ready, output, 1: high only in RUN.
- lock_loss_cnt, output, LOSS_CNT_W: saturating count of RUN-to-LOST transitions.
- timeout, output, 1: sticky lock-timeout flag (tied 0 without the optional feature).

Behaviour:
- Sync:
  - pll_lock passes through a 2-flop synchroniser to give lock_s.
  - Both flops clear to 0 on reset.
  - All decisions use lock_s, so there is 2 cycles of input latency.
- Reset (synchronous, active-high):
  - state=WAIT_LOCK, counter=0, sys_reset=1, ready=0, lock_loss_cnt=0, timeout=0.
  - reset asserted mid-operation forces this on the next edge from any state.
- One down-counter/up-counter (cnt) is shared by all states. Its width is clog2 of max(STABLE_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES)+1.
- States (sys_reset=1 in every state except RUN):
  - WAIT_LOCK:
    - cnt counts cycles.
    - lock_s=1 → go to STABILIZE with cnt=1.
  - STABILIZE:
    - lock_s=0 → go to WAIT_LOCK with cnt=0 (restart qualification).
    - Otherwise cnt increments.
    - When cnt==STABLE_CYCLES with lock_s=1 → go to HOLD with cnt=0.
  - HOLD:
    - lock_s=0 → go to WAIT_LOCK with cnt=0.
    - Otherwise cnt increments.
    - At cnt==HOLD_CYCLES-1 → go to RUN.
  - RUN:
    - sys_reset=0, ready=1, both registered.
    - lock_s=0 → go to LOST. sys_reset rises the same edge, so it is high in the first cycle of LOST.
  - LOST:
    - Entered for exactly one cycle.
    - lock_loss_cnt increments and saturates at all-ones (no wrap).
    - Always goes to WAIT_LOCK with cnt=0.
- Latency:
  - From the pll_lock rising edge with lock held steady, sys_reset falls after 2 + STABLE_CYCLES + HOLD_CYCLES (+1 state-entry) cycles.
  - The bench checks the exact value: 2+STABLE_CYCLES+HOLD_CYCLES+1.
- Glitches: a lock_s drop of 1 cycle in STABILIZE or HOLD restarts qualification fully. No partial credit.
- Simultaneous events: lock loss in the same cycle that the STABILIZE or HOLD terminal count is reached → lock loss wins (go to WAIT_LOCK).
- sys_reset and ready are driven directly from registers (glitch-free). sys_reset is never low when ready is low.

Optional Feature:
- Macro: PLL_SEQ_TIMEOUT_EN.
- Defined:
  - In WAIT_LOCK, when cnt reaches TIMEOUT_CYCLES-1, timeout is set and held until reset.
  - cnt saturates there (no further timeout events).
  - The sequencer keeps waiting, so a later lock still proceeds normally, and timeout stays 1.
- Undefined:
  - timeout tied to 0.
  - WAIT_LOCK does not count (cnt held at 0), and the comparator logic is not built.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state typedef (WAIT_LOCK, STABILIZE, HOLD, RUN, LOST; 3-bit encoding);
  - a clog2-based counter-width constant function.
- One natural sub-module: sync_2ff (parameterised-width 2-flop synchroniser with synchronous reset), reusable for other asynchronous inputs.

Test Plan:
- Clean lock (STABLE_CYCLES=8, HOLD_CYCLES=4): pll_lock rises at cycle 10 and stays high → sys_reset falls and ready rises at cycle 10+2+8+4+1=25; lock_loss_cnt=0.
- Glitch in STABILIZE: pll_lock high for 5 cycles, low for 1, then high → qualification restarts; sys_reset falls 15 cycles after the final rise (2+8+4+1).
- Loss in RUN: after ready=1, drop pll_lock → sys_reset=1 and ready=0 exactly 3 edges later; lock_loss_cnt=1; relock releases again after the full qualification.
- Saturation (LOSS_CNT_W=2): 5 lock-loss events in RUN → lock_loss_cnt reads 1,2,3,3,3.
- Reset mid-HOLD: assert reset during HOLD → next edge gives state=WAIT_LOCK, sys_reset=1, counters=0; lock_loss_cnt cleared.
- PLL_SEQ_TIMEOUT_EN (TIMEOUT_CYCLES=20): pll_lock held low → timeout=1 at cycle 20 after reset; later lock → ready=1 while timeout stays 1. Macro undefined → timeout stays 0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StWaitLock  = 3'd0,
    StStabilize = 3'd1,
    StHold      = 3'd2,
    StRun       = 3'd3,
    StLost      = 3'd4
  } seq_state_e;

  // Width of a counter that must reach the largest of the three limits.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, synchronous active-high reset.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock on the reference clock and sequences the downstream reset.
// Optional lock timeout flag is built when PLL_SEQ_TIMEOUT_EN is defined.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned LOSS_CNT_W     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  pll_lock_i,
  output logic                  sys_reset_o,
  output logic                  ready_o,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt_o,
  output logic                  timeout_o
);

  localparam int unsigned CntW = cnt_width(STABLE_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] StableCnt = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_CYCLES - 1);

  logic                  lock_s;
  seq_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  sys_reset_q, sys_reset_d;
  logic                  ready_q, ready_d;

  sync_2ff #(
    .Width (1)
  ) u_lock_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (pll_lock_i),
    .q_o     (lock_s)
  );

`ifdef PLL_SEQ_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  logic timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
`ifdef PLL_SEQ_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      StWaitLock: begin
        if (lock_s) begin
          state_d = StStabilize;
          cnt_d   = CntW'(1);
`ifdef PLL_SEQ_TIMEOUT_EN
        end else if (cnt_q == TimeoutLast) begin
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`else
        end else begin
          cnt_d = '0;
`endif
        end
      end
      StStabilize: begin
        // Lock loss takes priority over the terminal count.
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableCnt) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d = StLost;
          if (loss_q != '1) loss_d = loss_q + LOSS_CNT_W'(1);
        end
      end
      StLost: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase
    sys_reset_d = (state_d != StRun);
    ready_d     = (state_d == StRun);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StWaitLock;
      cnt_q       <= '0;
      loss_q      <= '0;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loss_q      <= loss_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
    end
  end

`ifdef PLL_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) timeout_q <= 1'b0;
    else         timeout_q <= timeout_d;
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign sys_reset_o     = sys_reset_q;
  assign ready_o         = ready_q;
  assign lock_loss_cnt_o = loss_q;

endmodule
